// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmitter. A word is taken over a valid/ready handshake
// and sent as one frame: a start bit, DATA_BITS data bits LSB first, an
// optional parity bit, then STOP_BITS stop bits. Every line bit lasts
// BPS_DIV = CLK_FREQ/BAUD clock cycles.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active high (line forced idle-high)
//   tx_valid  producer has a word to send
//   tx_data   word to send, sampled only when the word is accepted in IDLE
//   tx_ready  high while idle and able to accept a word
//   tx_busy   high while a frame is on the line (complement of tx_ready)
//   tx_done   one-cycle pulse in the last cycle of the final stop bit
//   sci_tx    registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLK_FREQ  = 25000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 sci_tx
);

    localparam int BPS_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W   = (BPS_DIV > 1) ? $clog2(BPS_DIV) : 1;

    localparam logic [CNT_W-1:0] BAUD_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BPS_DIV - 1);
    // tx_done is registered, so it is set one cycle ahead of the final cycle.
    localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(BPS_DIV - 2);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY < 0 || PARITY > 2 || BPS_DIV < 4) begin : g_bad_params
            $error("uart_tx_frame: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     baud_cnt_r;
    logic [3:0]           bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_r;
    logic                 sci_tx_r;
    logic                 tx_ready_r;
    logic                 tx_busy_r;
    logic                 tx_done_r;
    logic                 baud_end_s;

    // Parity of a data word: odd mode inverts the XOR reduction.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
        logic x;
        x = ^word;
        if (PARITY == 1) begin
            return ~x;
        end else begin
            return x;
        end
    endfunction

    // Last cycle of the current line bit.
    assign baud_end_s = (baud_cnt_r == BAUD_LAST);

    assign tx_ready = tx_ready_r;
    assign tx_busy  = tx_busy_r;
    assign tx_done  = tx_done_r;
    assign sci_tx   = sci_tx_r;

    // Frame sequencer: state, baud/bit counters, shift register and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= 4'd0;
            shift_r    <= {DATA_BITS{1'b0}};
            par_r      <= 1'b0;
            sci_tx_r   <= 1'b1;
            tx_ready_r <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;

            if (state_r == ST_IDLE || baud_end_s) begin
                baud_cnt_r <= BAUD_ZERO;
            end else begin
                baud_cnt_r <= baud_cnt_r + BAUD_ONE;
            end

            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= 4'd0;
                    if (tx_valid) begin
                        // Parity is taken from the word being latched, so
                        // later changes on tx_data cannot disturb it.
                        shift_r    <= tx_data;
                        par_r      <= parity_bit(tx_data);
                        sci_tx_r   <= 1'b0;
                        tx_ready_r <= 1'b0;
                        tx_busy_r  <= 1'b1;
                        state_r    <= ST_START;
                    end else begin
                        sci_tx_r <= 1'b1;
                    end
                end

                ST_START: begin
                    if (baud_end_s) begin
                        sci_tx_r  <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= 4'd0;
                        state_r   <= ST_DATA;
                    end else begin
                        sci_tx_r <= 1'b0;
                    end
                end

                ST_DATA: begin
                    if (baud_end_s) begin
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= 4'd0;
                            if (PARITY != 0) begin
                                sci_tx_r <= par_r;
                                state_r  <= ST_PAR;
                            end else begin
                                sci_tx_r <= 1'b1;
                                state_r  <= ST_STOP;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            sci_tx_r  <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                end

                ST_PAR: begin
                    if (baud_end_s) begin
                        sci_tx_r  <= 1'b1;
                        bit_cnt_r <= 4'd0;
                        state_r   <= ST_STOP;
                    end else begin
                        sci_tx_r <= par_r;
                    end
                end

                ST_STOP: begin
                    sci_tx_r <= 1'b1;
                    if (bit_cnt_r == STOP_LAST && baud_cnt_r == BAUD_PRE) begin
                        tx_done_r <= 1'b1;
                    end else begin
                        tx_done_r <= 1'b0;
                    end
                    if (baud_end_s) begin
                        if (bit_cnt_r == STOP_LAST) begin
                            bit_cnt_r  <= 4'd0;
                            tx_ready_r <= 1'b1;
                            tx_busy_r  <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                end

                default: begin
                    bit_cnt_r  <= 4'd0;
                    sci_tx_r   <= 1'b1;
                    tx_ready_r <= 1'b1;
                    tx_busy_r  <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five instances with different parameter sets.
// Expected frames go onto a scoreboard queue when a word is driven; a line
// monitor per instance decodes each frame at mid-bit and pops/compares.
module tb_uart_tx_frame;

    localparam int N = 5;
    // 0: 8N1 217, 1: 8E1, 2: 8O1, 3: 5N2, 4: 8N1 at 50 MHz / 9600
    localparam int BPS   [N] = '{217, 217, 217, 217, 5208};
    localparam int NBITS [N] = '{8, 8, 8, 5, 8};
    localparam int PARM  [N] = '{0, 2, 1, 0, 0};
    localparam int NSTOP [N] = '{1, 1, 1, 2, 1};

    logic         clk = 1'b0;
    logic [N-1:0] rst_a;
    logic [N-1:0] tx_valid_a;
    logic [N-1:0] abort_a;
    logic [8:0]   tx_data_a [N];
    wire  [N-1:0] tx_ready_a;
    wire  [N-1:0] tx_busy_a;
    wire  [N-1:0] tx_done_a;
    wire  [N-1:0] sci_tx_a;

    int     n_cmp = 0;
    int     n_fail = 0;
    int     comp_err = 0;
    longint cyc = 0;
    logic   prev4 = 1'b1;
    longint edges4 [$];

    typedef struct { int inst; logic [12:0] frame; } sb_t;
    sb_t sb [$];

    typedef struct { int inst; logic [8:0] data; logic [12:0] frame; } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    uart_tx_frame u0 (.clk(clk), .rst(rst_a[0]), .tx_valid(tx_valid_a[0]), .tx_data(tx_data_a[0][7:0]),
                      .tx_ready(tx_ready_a[0]), .tx_busy(tx_busy_a[0]), .tx_done(tx_done_a[0]), .sci_tx(sci_tx_a[0]));
    uart_tx_frame #(.PARITY(2)) u1 (.clk(clk), .rst(rst_a[1]), .tx_valid(tx_valid_a[1]), .tx_data(tx_data_a[1][7:0]),
                      .tx_ready(tx_ready_a[1]), .tx_busy(tx_busy_a[1]), .tx_done(tx_done_a[1]), .sci_tx(sci_tx_a[1]));
    uart_tx_frame #(.PARITY(1)) u2 (.clk(clk), .rst(rst_a[2]), .tx_valid(tx_valid_a[2]), .tx_data(tx_data_a[2][7:0]),
                      .tx_ready(tx_ready_a[2]), .tx_busy(tx_busy_a[2]), .tx_done(tx_done_a[2]), .sci_tx(sci_tx_a[2]));
    uart_tx_frame #(.DATA_BITS(5), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst_a[3]), .tx_valid(tx_valid_a[3]),
                      .tx_data(tx_data_a[3][4:0]), .tx_ready(tx_ready_a[3]), .tx_busy(tx_busy_a[3]),
                      .tx_done(tx_done_a[3]), .sci_tx(sci_tx_a[3]));
    uart_tx_frame #(.CLK_FREQ(50000000), .BAUD(9600)) u4 (.clk(clk), .rst(rst_a[4]), .tx_valid(tx_valid_a[4]),
                      .tx_data(tx_data_a[4][7:0]), .tx_ready(tx_ready_a[4]), .tx_busy(tx_busy_a[4]),
                      .tx_done(tx_done_a[4]), .sci_tx(sci_tx_a[4]));

    always @(posedge clk) cyc <= cyc + 1;

    // Record every sci_tx transition of the 9600-baud instance.
    always @(negedge clk) begin
        if (sci_tx_a[4] !== prev4) edges4.push_back(cyc);
        prev4 <= sci_tx_a[4];
    end

    // tx_ready and tx_busy must always be complementary.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++)
            if (tx_ready_a[i] === tx_busy_a[i]) comp_err <= comp_err + 1;
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic int frame_bits(input int i);
        return 1 + NBITS[i] + ((PARM[i] != 0) ? 1 : 0) + NSTOP[i];
    endfunction

    // Reference frame, bit 0 = start bit.
    function automatic logic [12:0] exp_frame(input int i, input logic [8:0] d);
        logic [12:0] f;
        logic        x;
        int          p;
        f = 13'd0;
        x = 1'b0;
        p = 1;
        for (int b = 0; b < NBITS[i]; b++) begin
            f[p] = d[b];
            x = x ^ d[b];
            p++;
        end
        if (PARM[i] == 2) begin f[p] = x; p++; end
        if (PARM[i] == 1) begin f[p] = ~x; p++; end
        for (int s = 0; s < NSTOP[i]; s++) begin f[p] = 1'b1; p++; end
        return f;
    endfunction

    task automatic monitor(input int i);
        logic        prev;
        logic [12:0] got;
        int          nb;
        int          k;
        prev = 1'b1;
        nb = frame_bits(i);
        forever begin
            @(negedge clk);
            if (rst_a[i] === 1'b1) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && sci_tx_a[i] === 1'b0) begin
                got = 13'd0;
                repeat (BPS[i] / 2) @(negedge clk);
                for (int b = 0; b < nb; b++) begin
                    got[b] = sci_tx_a[i];
                    if (b != nb - 1) repeat (BPS[i]) @(negedge clk);
                end
                if (abort_a[i] === 1'b1) begin
                    abort_a[i] = 1'b0;
                end else begin
                    k = -1;
                    for (int q = 0; q < sb.size(); q++)
                        if (k < 0 && sb[q].inst == i) k = q;
                    chk("sb_entry_present", (k >= 0) ? 1 : 0, 1);
                    if (k >= 0) begin
                        chk($sformatf("frame_inst%0d", i), got, sb[k].frame);
                        sb.delete(k);
                    end
                end
                prev = sci_tx_a[i];
            end else begin
                prev = sci_tx_a[i];
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);
    initial monitor(3);
    initial monitor(4);

    task automatic wait_ready(input int i, input int lim);
        int n;
        n = 0;
        while (tx_ready_a[i] !== 1'b1 && n < lim) begin @(negedge clk); n++; end
        if (n >= lim) chk("ready_timeout", tx_ready_a[i], 1);
    endtask

    task automatic wait_busy(input int i, input logic lvl, input int lim, input string name);
        int n;
        n = 0;
        while (tx_busy_a[i] !== lvl && n < lim) begin @(negedge clk); n++; end
        if (n >= lim) chk(name, tx_busy_a[i], lvl);
    endtask

    task automatic send(input int i, input logic [8:0] data, input logic [12:0] expf);
        int   n, busy_c, done_c, nb, lim;
        sb_t  e;
        nb = frame_bits(i);
        lim = 4 * nb * BPS[i];
        wait_ready(i, lim);
        tx_valid_a[i] = 1'b1;
        tx_data_a[i] = data;
        e.inst = i;
        e.frame = expf;
        sb.push_back(e);
        @(negedge clk);
        tx_valid_a[i] = 1'b0;
        tx_data_a[i] = ~data;
        chk("start_latency", sci_tx_a[i], 0);
        busy_c = 0; done_c = 0; n = 0;
        while (tx_busy_a[i] === 1'b1 && n < lim) begin
            busy_c++;
            if (tx_done_a[i] === 1'b1) done_c++;
            @(negedge clk);
            n++;
        end
        chk("busy_cycles", busy_c, nb * BPS[i]);
        chk("done_pulses", done_c, 1);
        chk("idle_line", sci_tx_a[i], 1);
    endtask

    initial begin
        int idle, busy_seen, done_seen;
        rst_a = '1;
        tx_valid_a = '0;
        abort_a = '0;
        for (int i = 0; i < N; i++) tx_data_a[i] = 9'd0;

        vecs[0] = '{0, 9'h0A5, 13'b0001101001010};
        vecs[1] = '{0, 9'h000, 13'b0001000000000};
        vecs[2] = '{0, 9'h0FF, 13'b0001111111110};
        vecs[3] = '{1, 9'h0A5, 13'b0010101001010};
        vecs[4] = '{2, 9'h0A5, 13'b0011101001010};
        vecs[5] = '{2, 9'h007, 13'b0010000001110};
        vecs[6] = '{1, 9'h007, 13'b0011000001110};
        vecs[7] = '{3, 9'h0F3, 13'b0000011100110};
        vecs[8] = '{3, 9'h00A, 13'b0000011010100};

        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("reset_sci", sci_tx_a[i], 1);
            chk("reset_ready", tx_ready_a[i], 1);
            chk("reset_busy", tx_busy_a[i], 0);
            chk("reset_done", tx_done_a[i], 0);
        end
        rst_a = '0;
        @(negedge clk);

        fork
            begin : baud_branch
                edges4.delete();
                send(4, 9'h055, 13'b0001010101010);
                chk("baud_edge_count", edges4.size(), 10);
                for (int k = 1; k < edges4.size(); k++)
                    chk("baud_period", edges4[k] - edges4[k-1], 5208);
            end
            begin : main_branch
                for (int v = 0; v < 9; v++) send(vecs[v].inst, vecs[v].data, vecs[v].frame);

                // Held valid: two frames, one idle cycle between, data change mid-frame.
                wait_ready(0, 5000);
                tx_valid_a[0] = 1'b1;
                tx_data_a[0] = 9'h055;
                sb.push_back('{0, exp_frame(0, 9'h055)});
                @(negedge clk);
                chk("hs_busy", tx_busy_a[0], 1);
                repeat (3 * 217) @(negedge clk);
                tx_data_a[0] = 9'h0AA;
                sb.push_back('{0, exp_frame(0, 9'h0AA)});
                wait_busy(0, 1'b0, 5000, "hs_end1_timeout");
                chk("hs_idle_line", sci_tx_a[0], 1);
                idle = 0;
                while (tx_busy_a[0] !== 1'b1 && idle < 10) begin idle++; @(negedge clk); end
                chk("hs_idle_gap", idle, 1);
                repeat (2 * 217) @(negedge clk);
                tx_valid_a[0] = 1'b0;
                tx_data_a[0] = 9'h000;
                repeat (217) @(negedge clk);
                tx_valid_a[0] = 1'b1;
                tx_data_a[0] = 9'h011;
                @(negedge clk);
                tx_valid_a[0] = 1'b0;
                wait_busy(0, 1'b0, 5000, "hs_end2_timeout");
                busy_seen = 0;
                repeat (3 * 217) begin
                    @(negedge clk);
                    if (tx_busy_a[0] === 1'b1) busy_seen++;
                end
                chk("hs_no_third_frame", busy_seen, 0);

                // Reset during data bit 3 of 0xF0.
                wait_ready(0, 5000);
                tx_valid_a[0] = 1'b1;
                tx_data_a[0] = 9'h0F0;
                @(negedge clk);
                tx_valid_a[0] = 1'b0;
                repeat (4 * 217 + 99) @(negedge clk);
                chk("rst_pre_bit3", sci_tx_a[0], 0);
                abort_a[0] = 1'b1;
                rst_a[0] = 1'b1;
                #1;
                chk("rst_sci", sci_tx_a[0], 1);
                chk("rst_ready", tx_ready_a[0], 1);
                chk("rst_busy", tx_busy_a[0], 0);
                done_seen = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (tx_done_a[0] === 1'b1) done_seen++;
                end
                rst_a[0] = 1'b0;
                repeat (10 * 217) begin
                    @(negedge clk);
                    if (tx_done_a[0] === 1'b1) done_seen++;
                end
                chk("rst_no_done", done_seen, 0);
                chk("rst_ready_after", tx_ready_a[0], 1);
                send(0, 9'h03C, exp_frame(0, 9'h03C));
            end
        join

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("ready_busy_complement", comp_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
